// File: rtl/btn_pkg.sv
// Shared state encodings for the push-button debouncer channels.
package btn_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CHK_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_CHK_REL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_CHK_PRESS = ST_CHK_PRESS,
        S_HELD      = ST_HELD,
        S_CHK_REL   = ST_CHK_REL
    } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter and a
// four-state FSM producing a registered level plus press/release pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_rel
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg, sync2_reg;
    btn_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             rel_reg, rel_next;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
        end else begin
            sync1_reg <= i_btn;
            sync2_reg <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            press_reg <= press_next;
            rel_reg   <= rel_next;
        end
    end

    // The counter is compared before incrementing, so it never exceeds CNT_MAX.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (sync2_reg) begin
                    state_next = S_CHK_PRESS;
                    cnt_next   = '0;
                end
            end
            S_CHK_PRESS: begin
                if (!sync2_reg) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_HELD;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!sync2_reg) begin
                    state_next = S_CHK_REL;
                    cnt_next   = '0;
                end
            end
            S_CHK_REL: begin
                if (sync2_reg) begin
                    state_next = S_HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    rel_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == S_HELD) || (state_next == S_CHK_REL);
    end

    assign o_level = level_reg;
    assign o_press = press_reg;
    assign o_rel   = rel_reg;

endmodule

// File: rtl/btn_debounce.sv
// Debounces the raw button vector; one independent channel per button,
// outputs are just the concatenation of the per-channel flops.
module btn_debounce #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clock   (clock),
                .i_reset (i_reset),
                .i_btn   (i_btn[gi]),
                .o_level (o_btn_level[gi]),
                .o_press (o_btn_press[gi]),
                .o_rel   (o_btn_release[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button traffic,
// every cycle checked against a run-length reference model.
module tb_btn_debounce;

    localparam int N = 4;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         i_reset = 1'b1;
    logic [N-1:0] i_btn = '0;
    logic [N-1:0] o_btn_level, o_btn_press, o_btn_release;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the two-cycle input delay, then a level that flips once
    // the delayed input has disagreed with it for D+1 consecutive samples.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    int           m_run [N];

    int press_cnt [N];
    int rel_cnt   [N];

    btn_debounce #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_btn        (i_btn),
        .o_btn_level  (o_btn_level),
        .o_btn_press  (o_btn_press),
        .o_btn_release(o_btn_release)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (i_reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < N; c++) begin
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D + 1) begin
                        if (m_s2[c]) m_press[c] = 1'b1;
                        else         m_rel[c]   = 1'b1;
                        m_lvl[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = i_btn;
        end
    endtask

    // One clock: inputs are already set, sample outputs on the falling edge.
    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check("level",   32'(o_btn_level),   32'(m_lvl));
        check("press",   32'(o_btn_press),   32'(m_press));
        check("release", 32'(o_btn_release), 32'(m_rel));
        for (int c = 0; c < N; c++) begin
            press_cnt[c] += int'(o_btn_press[c]);
            rel_cnt[c]   += int'(o_btn_release[c]);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
        end
    endtask

    int hold [N];

    initial begin
        clear_counts();
        // Reset with all buttons held, then the press appears on the 11th edge.
        i_reset = 1'b1;
        i_btn   = 4'hF;
        repeat (3) begin
            step();
            check("rst_outputs", 32'({o_btn_level, o_btn_press, o_btn_release}), 32'h0);
        end
        i_reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("rst_press_time", 32'(o_btn_press), (e == 11) ? 32'hF : 32'h0);
        end
        check("rst_level", 32'(o_btn_level), 32'hF);
        $display("scenario reset: level=%b", o_btn_level);

        i_btn = 4'h0;
        repeat (14) step();
        check("all_released", 32'(o_btn_level), 32'h0);

        // Clean press on channel 0.
        i_btn = 4'h1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("press0_time", 32'(o_btn_press), (e == 11) ? 32'h1 : 32'h0);
        end
        check("press0_level", 32'(o_btn_level), 32'h1);
        $display("scenario clean press: level=%b", o_btn_level);

        // Bounce on channel 1, then a steady press.
        clear_counts();
        for (int c = 0; c < 30; c++) begin
            i_btn[1] = ((c / 3) % 2 == 0);
            step();
        end
        i_btn[1] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            check("bounce1_time", 32'(o_btn_press[1]), (e == 11) ? 32'h1 : 32'h0);
        end
        check("bounce1_presses", 32'(press_cnt[1]), 32'd1);
        check("bounce1_releases", 32'(rel_cnt[1]), 32'd0);
        $display("scenario bounce: presses=%0d releases=%0d", press_cnt[1], rel_cnt[1]);

        // High glitch on channel 2, low glitch on held channel 0.
        clear_counts();
        i_btn[2] = 1'b1;
        i_btn[0] = 1'b0;
        repeat (5) step();
        i_btn[2] = 1'b0;
        i_btn[0] = 1'b1;
        repeat (14) step();
        check("glitch2_pulses", 32'(press_cnt[2] + rel_cnt[2]), 32'd0);
        check("glitch2_level", 32'(o_btn_level[2]), 32'd0);
        check("glitch0_release", 32'(rel_cnt[0]), 32'd0);
        check("glitch0_level", 32'(o_btn_level[0]), 32'd1);
        $display("scenario glitch: level=%b", o_btn_level);

        // Simultaneous channels.
        i_btn = 4'h0;
        repeat (14) step();
        i_btn = 4'b1001;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("multi_press", 32'(o_btn_press), (e == 11) ? 32'h9 : 32'h0);
        end
        i_btn = 4'b0000;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("multi_release", 32'(o_btn_release), (e == 11) ? 32'h9 : 32'h0);
        end
        $display("scenario simultaneous: level=%b", o_btn_level);

        // Reset while channel 3 is mid-count (cnt=4 after its 7th edge).
        i_btn = 4'h8;
        repeat (7) step();
        i_reset = 1'b1;
        repeat (3) begin
            step();
            check("midrst_outputs", 32'({o_btn_level, o_btn_press, o_btn_release}), 32'h0);
        end
        i_reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("midrst_press", 32'(o_btn_press), (e == 11) ? 32'h8 : 32'h0);
        end
        $display("scenario mid-count reset: level=%b", o_btn_level);

        // Random traffic: per-channel hold times spanning both sides of D+1.
        for (int c = 0; c < N; c++) hold[c] = 1;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    i_btn[c] = ~i_btn[c];
                    hold[c]  = int'($urandom_range(1, 16));
                end
            end
            i_reset = ($urandom_range(0, 599) == 0);
            step();
        end
        i_reset = 1'b0;
        $display("scenario random: done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
